// File: rtl/mem_stage.sv
// MEM pipeline stage: byte-addressable data memory with sized loads/stores,
// misalignment flagging, post-reset zero sweep and a registered debug read port.
module mem_stage #(
    parameter int unsigned INST_SZ     = 32,
    parameter int unsigned MEM_ADDR_SZ = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [INST_SZ-1:0]     i_alu_result_E,
    input  logic [INST_SZ-1:0]     i_operand_b_E,
    input  logic                   i_mem_read_MC,
    input  logic                   i_mem_write_MC,
    input  logic [2:0]             i_bhw_MC,
    input  logic [MEM_ADDR_SZ-1:0] i_debug_addr,
    output logic [INST_SZ-1:0]     o_read_data_M,
    output logic                   o_misaligned_M,
    output logic                   o_ready_M,
    output logic [INST_SZ-1:0]     o_debug_data
);

    localparam int unsigned DEPTH = 2 ** MEM_ADDR_SZ;
    localparam int unsigned NB    = INST_SZ / 8;

    typedef enum logic [0:0] {
        StClear,
        StRun
    } state_e;

    state_e                 r_state;
    logic [MEM_ADDR_SZ-1:0] r_clr_ptr;
    logic                   r_ready;
    logic [INST_SZ-1:0]     r_read_data;
    logic                   r_misaligned;
    logic [INST_SZ-1:0]     r_debug_data;
    logic [INST_SZ-1:0]     r_mem [DEPTH];

    // ------------------------------------------------------------------
    // Address and size decode
    // ------------------------------------------------------------------
    logic [MEM_ADDR_SZ-1:0] w_word_addr;
    logic [1:0]             w_off;
    logic                   w_unused_addr;
    logic                   w_is_byte;
    logic                   w_is_half;
    logic                   w_is_word;
    logic                   w_is_unsigned;
    logic                   w_misaligned;
    logic                   w_run;
    logic                   w_access;
    logic                   w_do_load;
    logic                   w_do_store;

    // Upper address bits fall outside the memory and simply wrap.
    assign w_word_addr   = i_alu_result_E[MEM_ADDR_SZ+1:2];
    assign w_off         = i_alu_result_E[1:0];
    assign w_unused_addr = ^i_alu_result_E[INST_SZ-1:MEM_ADDR_SZ+2];

    assign w_is_byte     = (i_bhw_MC[1:0] == 2'b00);
    assign w_is_half     = (i_bhw_MC[1:0] == 2'b01);
    assign w_is_word     = i_bhw_MC[1];
    assign w_is_unsigned = i_bhw_MC[2];

    assign w_misaligned  = (w_is_half & w_off[0]) | (w_is_word & (w_off != 2'b00));
    assign w_run         = (r_state == StRun);
    assign w_access      = i_mem_read_MC | i_mem_write_MC;
    assign w_do_load     = w_run & i_mem_read_MC & ~w_misaligned;
    assign w_do_store    = w_run & i_mem_write_MC & ~w_misaligned;

    // ------------------------------------------------------------------
    // Load formatting
    // ------------------------------------------------------------------
    logic [INST_SZ-1:0] w_rd_word;
    logic [7:0]         w_rd_byte;
    logic [15:0]        w_rd_half;
    logic [INST_SZ-1:0] w_load_data;

    assign w_rd_word = r_mem[w_word_addr];
    assign w_rd_byte = w_rd_word[{w_off, 3'b000} +: 8];
    assign w_rd_half = w_off[1] ? w_rd_word[16 +: 16] : w_rd_word[0 +: 16];

    always_comb begin
        w_load_data = '0;
        if (w_is_word) begin
            w_load_data = w_rd_word;
        end else if (w_is_half) begin
            w_load_data = {{(INST_SZ-16){~w_is_unsigned & w_rd_half[15]}}, w_rd_half};
        end else begin
            w_load_data = {{(INST_SZ-8){~w_is_unsigned & w_rd_byte[7]}}, w_rd_byte};
        end
    end

    // ------------------------------------------------------------------
    // Write port: shared by the clear sweep and aligned stores
    // ------------------------------------------------------------------
    logic                   w_wr_en;
    logic [MEM_ADDR_SZ-1:0] w_wr_addr;
    logic [NB-1:0]          w_wr_be;
    logic [INST_SZ-1:0]     w_wr_data;

    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = '0;
        w_wr_be   = '0;
        w_wr_data = '0;
        if (!i_reset) begin
            if (r_state == StClear) begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_clr_ptr;
                w_wr_be   = '1;
            end else if (w_do_store) begin
                w_wr_en   = 1'b1;
                w_wr_addr = w_word_addr;
                if (w_is_word) begin
                    w_wr_be   = '1;
                    w_wr_data = i_operand_b_E;
                end else if (w_is_half) begin
                    w_wr_be   = NB'(2'b11) << {w_off[1], 1'b0};
                    w_wr_data = {(NB/2){i_operand_b_E[15:0]}};
                end else if (w_is_byte) begin
                    w_wr_be   = NB'(1) << w_off;
                    w_wr_data = {NB{i_operand_b_E[7:0]}};
                end
            end
        end
    end

    // Byte-lane write enables; the array itself is never reset.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (w_wr_be[b]) begin
                    r_mem[w_wr_addr][8*b +: 8] <= w_wr_data[8*b +: 8];
                end
            end
        end
    end

    // Old contents are returned on a same-cycle write to the debug address.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_debug_data <= '0;
        end else begin
            r_debug_data <= r_mem[i_debug_addr];
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= StClear;
            r_clr_ptr    <= '0;
            r_ready      <= 1'b0;
            r_read_data  <= '0;
            r_misaligned <= 1'b0;
        end else begin
            unique case (r_state)
                StClear: begin
                    r_clr_ptr    <= r_clr_ptr + 1'b1;
                    r_read_data  <= '0;
                    r_misaligned <= 1'b0;
                    if (&r_clr_ptr) begin
                        r_state <= StRun;
                        r_ready <= 1'b1;
                    end
                end
                StRun: begin
                    r_ready      <= 1'b1;
                    r_misaligned <= w_access & w_misaligned;
                    if (w_do_load) begin
                        r_read_data <= w_load_data;
                    end
                end
            endcase
        end
    end

    assign o_read_data_M  = r_read_data;
    assign o_misaligned_M = r_misaligned;
    assign o_ready_M      = r_ready;
    assign o_debug_data   = r_debug_data;

endmodule
